// File: rtl/mixer_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mixer_ctrl_if
// Description : Command bus (valid/ready) between the control logic or host
//               bridge and the mixer control plane.
// Revision    : 1.0 - initial release
// ============================================================================
interface mixer_ctrl_if #(
  parameter int CHANNELS  = 4,
  parameter int VOL_WIDTH = 4
);
  localparam int CH_W = $clog2(CHANNELS) + 1;

  logic                 cmd_valid_in;
  logic                 cmd_ready_out;
  logic [1:0]           cmd_op_in;
  logic [CH_W-1:0]      cmd_channel_in;
  logic [VOL_WIDTH-1:0] cmd_value_in;

  modport master (
    output cmd_valid_in, cmd_op_in, cmd_channel_in, cmd_value_in,
    input  cmd_ready_out
  );

  modport slave (
    input  cmd_valid_in, cmd_op_in, cmd_channel_in, cmd_value_in,
    output cmd_ready_out
  );
endinterface
`default_nettype wire

// File: rtl/mixer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mixer_ctrl
// Description : Per-channel volume/mute control for the audio mixer. Commands
//               are buffered in a small FIFO and applied between sample ticks;
//               volume ramps one code per tick and mute fades out first.
// Revision    : 1.0 - initial release
// ============================================================================
module mixer_ctrl #(
  parameter int CHANNELS   = 4,
  parameter int VOL_WIDTH  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          sample_tick_in,
  mixer_ctrl_if.slave                   cmd,
  output logic [CHANNELS*VOL_WIDTH-1:0] volume_out,
  output logic [CHANNELS-1:0]           mute_out,
  output logic                          busy_out,
  output logic                          err_out
);
  localparam int CH_W    = $clog2(CHANNELS) + 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = 2 + CH_W + VOL_WIDTH;

  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CH_W-1:0]  CH_LIMIT = CH_W'(CHANNELS);
  localparam logic [VOL_WIDTH-1:0] VOL_ONE  = VOL_WIDTH'(1);
  localparam logic [VOL_WIDTH-1:0] VOL_ZERO = '0;

  localparam logic [1:0] OP_SET_VOL = 2'b00;
  localparam logic [1:0] OP_MUTE    = 2'b01;
  localparam logic [1:0] OP_UNMUTE  = 2'b10;
  localparam logic [1:0] OP_SET_ALL = 2'b11;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FADING = 2'd1,
    MUTED  = 2'd2
  } ch_state_t;

  // Command FIFO
  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [PTR_W:0]     count, count_nxt;
  logic               ready_q;
  logic               push, pop;

  logic [ENTRY_W-1:0]   head;
  logic [1:0]           head_op;
  logic [CH_W-1:0]      head_chan;
  logic [VOL_WIDTH-1:0] head_val;

  // Channel state
  logic [VOL_WIDTH-1:0] target   [CHANNELS];
  logic [VOL_WIDTH-1:0] cur      [CHANNELS];
  ch_state_t            st       [CHANNELS];
  logic [VOL_WIDTH-1:0] target_nxt [CHANNELS];
  logic [VOL_WIDTH-1:0] cur_nxt    [CHANNELS];
  ch_state_t            st_nxt     [CHANNELS];
  logic                 err_nxt, busy_nxt;

  // Ready is a registered "not full", so a pop never reaches it combinationally.
  assign push = cmd.cmd_valid_in & ready_q;
  assign pop  = (count != '0) & ~sample_tick_in;
  assign cmd.cmd_ready_out = ready_q;

  assign head      = fifo_mem[rd_ptr];
  assign head_op   = head[ENTRY_W-1 -: 2];
  assign head_chan = head[VOL_WIDTH +: CH_W];
  assign head_val  = head[VOL_WIDTH-1:0];

  // FIFO storage; contents need no reset because occupancy is tracked by count.
  always_ff @(posedge clk_in) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {cmd.cmd_op_in, cmd.cmd_channel_in, cmd.cmd_value_in};
    end
  end

  // Next FIFO occupancy from the push/pop pair.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  // Next channel state: ticks move volume, non-tick cycles apply the head command.
  always_comb begin
    err_nxt  = err_out;
    busy_nxt = (count_nxt != '0);
    for (int i = 0; i < CHANNELS; i++) begin
      target_nxt[i] = target[i];
      cur_nxt[i]    = cur[i];
      st_nxt[i]     = st[i];
      if (sample_tick_in) begin
        case (st[i])
          ACTIVE: begin
            if (cur[i] < target[i])      cur_nxt[i] = cur[i] + VOL_ONE;
            else if (cur[i] > target[i]) cur_nxt[i] = cur[i] - VOL_ONE;
          end
          FADING: begin
            if (cur[i] <= VOL_ONE) begin
              cur_nxt[i] = VOL_ZERO;
              st_nxt[i]  = MUTED;
            end else begin
              cur_nxt[i] = cur[i] - VOL_ONE;
            end
          end
          default: cur_nxt[i] = VOL_ZERO;
        endcase
      end else if (pop) begin
        case (head_op)
          OP_SET_VOL: if (head_chan == CH_W'(i)) target_nxt[i] = head_val;
          OP_SET_ALL: target_nxt[i] = head_val;
          OP_MUTE:    if (head_chan == CH_W'(i) && st[i] == ACTIVE) st_nxt[i] = FADING;
          default: begin
            if (head_chan == CH_W'(i)) begin
              if (st[i] == MUTED) cur_nxt[i] = VOL_ZERO;
              st_nxt[i] = ACTIVE;
            end
          end
        endcase
      end
      if (st_nxt[i] == FADING || (st_nxt[i] == ACTIVE && cur_nxt[i] != target_nxt[i])) begin
        busy_nxt = 1'b1;
      end
    end
    if (pop && head_op != OP_SET_ALL && head_chan >= CH_LIMIT) err_nxt = 1'b1;
  end

  // State register for FIFO control, channels and status flags.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ready_q  <= 1'b1;
      err_out  <= 1'b0;
      busy_out <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        target[i] <= '0;
        cur[i]    <= '0;
        st[i]     <= ACTIVE;
      end
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count    <= count_nxt;
      ready_q  <= (count_nxt != CNT_FULL);
      err_out  <= err_nxt;
      busy_out <= busy_nxt;
      for (int i = 0; i < CHANNELS; i++) begin
        target[i] <= target_nxt[i];
        cur[i]    <= cur_nxt[i];
        st[i]     <= st_nxt[i];
      end
    end
  end

  generate
    for (genvar g = 0; g < CHANNELS; g++) begin : g_out
      assign volume_out[g*VOL_WIDTH +: VOL_WIDTH] = cur[g];
      assign mute_out[g] = (st[g] == MUTED);
    end
  endgenerate
endmodule
`default_nettype wire

// File: tb/tb_mixer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mixer_ctrl
// Description : Scoreboard bench for mixer_ctrl (3 channels, 4-bit volume,
//               4-entry FIFO). Every tick pushes its expected outputs; a
//               monitor pops and compares at each tick edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mixer_ctrl;
  localparam int CH = 3;
  localparam int VW = 4;

  typedef struct packed {
    logic [CH*VW-1:0] vol;
    logic [CH-1:0]    mute;
    logic             busy_care;
    logic             busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0;
  logic [CH*VW-1:0] volume;
  logic [CH-1:0] mute;
  logic busy, err;
  int total = 0;
  int bad = 0;
  exp_t exp_q[$];

  mixer_ctrl_if #(.CHANNELS(CH), .VOL_WIDTH(VW)) cmd_if ();

  mixer_ctrl #(.CHANNELS(CH), .VOL_WIDTH(VW), .FIFO_DEPTH(4)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .sample_tick_in(tick), .cmd(cmd_if),
    .volume_out(volume), .mute_out(mute), .busy_out(busy), .err_out(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: every tick edge must match the oldest queued expectation.
  initial begin
    forever begin
      @(posedge clk);
      if (tick) begin
        #1;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL tick_no_expect: got vol=%h expected queued entry", volume);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (volume !== e.vol || mute !== e.mute || (e.busy_care && busy !== e.busy)) begin
            bad++;
            $display("FAIL tick: got vol=%h mute=%b busy=%b expected vol=%h mute=%b busy=%b",
                     volume, mute, busy, e.vol, e.mute, e.busy);
          end
        end
      end
    end
  end

  function automatic exp_t mk(input logic [3:0] v0, input logic [3:0] v1, input logic [3:0] v2,
                              input logic [2:0] m, input logic bc, input logic b);
    exp_t e;
    e.vol = {v2, v1, v0};
    e.mute = m;
    e.busy_care = bc;
    e.busy = b;
    return e;
  endfunction

  task automatic do_tick(input logic [3:0] v0, input logic [3:0] v1, input logic [3:0] v2,
                         input logic [2:0] m, input logic b);
    @(negedge clk);
    tick = 1'b1;
    exp_q.push_back(mk(v0, v1, v2, m, 1'b1, b));
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [2:0] ch, input logic [3:0] val);
    int waited;
    @(negedge clk);
    cmd_if.cmd_valid_in = 1'b1;
    cmd_if.cmd_op_in = op;
    cmd_if.cmd_channel_in = ch;
    cmd_if.cmd_value_in = val;
    waited = 0;
    while (!cmd_if.cmd_ready_out && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_if.cmd_ready_out) begin
      total++;
      bad++;
      $display("FAIL cmd_accept_timeout: got ready=0 expected 1");
    end
    @(negedge clk);
    cmd_if.cmd_valid_in = 1'b0;
  endtask

  // Lets the pop edge following an accepted command pass.
  task automatic idle();
    @(negedge clk);
  endtask

  initial begin
    cmd_if.cmd_valid_in = 1'b0;
    cmd_if.cmd_op_in = 2'b00;
    cmd_if.cmd_channel_in = '0;
    cmd_if.cmd_value_in = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_vol", 32'(volume), 32'h0);
    check("reset_mute", 32'(mute), 32'h0);
    check("reset_err", 32'(err), 32'h0);
    check("reset_ready", 32'(cmd_if.cmd_ready_out), 32'h1);
    check("reset_busy", 32'(busy), 32'h0);

    // Ramp ch1 0 -> 5
    send_cmd(2'b00, 3'd1, 4'd5);
    idle();
    check("ramp_busy_start", 32'(busy), 32'h1);
    do_tick(0, 1, 0, 3'b000, 1'b1);
    do_tick(0, 2, 0, 3'b000, 1'b1);
    do_tick(0, 3, 0, 3'b000, 1'b1);
    do_tick(0, 4, 0, 3'b000, 1'b1);
    do_tick(0, 5, 0, 3'b000, 1'b0);
    do_tick(0, 5, 0, 3'b000, 1'b0);
    do_tick(0, 5, 0, 3'b000, 1'b0);

    // ch2 to 3, then fade to mute
    send_cmd(2'b00, 3'd2, 4'd3);
    do_tick(0, 5, 1, 3'b000, 1'b1);
    do_tick(0, 5, 2, 3'b000, 1'b1);
    do_tick(0, 5, 3, 3'b000, 1'b0);
    send_cmd(2'b01, 3'd2, 4'd0);
    do_tick(0, 5, 2, 3'b000, 1'b1);
    do_tick(0, 5, 1, 3'b000, 1'b1);
    do_tick(0, 5, 0, 3'b100, 1'b0);
    send_cmd(2'b00, 3'd2, 4'd6);
    do_tick(0, 5, 0, 3'b100, 1'b0);
    send_cmd(2'b10, 3'd2, 4'd0);
    idle();
    check("unmute_mute_low", 32'(mute), 32'h0);
    check("unmute_busy", 32'(busy), 32'h1);
    for (int k = 1; k <= 6; k++) do_tick(0, 5, 4'(k), 3'b000, (k != 6));

    // ch0 up to 8, fade to 5, unmute back to 8 without muting
    send_cmd(2'b00, 3'd0, 4'd8);
    for (int k = 1; k <= 8; k++) do_tick(4'(k), 5, 6, 3'b000, (k != 8));
    send_cmd(2'b01, 3'd0, 4'd0);
    do_tick(7, 5, 6, 3'b000, 1'b1);
    do_tick(6, 5, 6, 3'b000, 1'b1);
    do_tick(5, 5, 6, 3'b000, 1'b1);
    send_cmd(2'b10, 3'd0, 4'd0);
    do_tick(6, 5, 6, 3'b000, 1'b1);
    do_tick(7, 5, 6, 3'b000, 1'b1);
    do_tick(8, 5, 6, 3'b000, 1'b0);

    // FIFO fill while ticks block pops
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tick = 1'b1;
      exp_q.push_back(mk(8, 5, 6, 3'b000, 1'b0, 1'b0));
      check($sformatf("fill_ready_%0d", k), 32'(cmd_if.cmd_ready_out), (k < 4) ? 32'h1 : 32'h0);
      cmd_if.cmd_valid_in = 1'b1;
      case (k)
        0: begin cmd_if.cmd_op_in = 2'b00; cmd_if.cmd_channel_in = 3'd0; cmd_if.cmd_value_in = 4'd2; end
        1: begin cmd_if.cmd_op_in = 2'b00; cmd_if.cmd_channel_in = 3'd1; cmd_if.cmd_value_in = 4'd3; end
        2: begin cmd_if.cmd_op_in = 2'b01; cmd_if.cmd_channel_in = 3'd2; cmd_if.cmd_value_in = 4'd0; end
        3: begin cmd_if.cmd_op_in = 2'b00; cmd_if.cmd_channel_in = 3'd0; cmd_if.cmd_value_in = 4'd4; end
        default: begin cmd_if.cmd_op_in = 2'b00; cmd_if.cmd_channel_in = 3'd1; cmd_if.cmd_value_in = 4'd9; end
      endcase
    end
    @(negedge clk);
    tick = 1'b0;
    check("full_ready_low", 32'(cmd_if.cmd_ready_out), 32'h0);
    @(negedge clk);
    check("pop_frees_slot", 32'(cmd_if.cmd_ready_out), 32'h1);
    @(negedge clk);
    cmd_if.cmd_valid_in = 1'b0;
    repeat (4) @(negedge clk);
    check("drain_ready", 32'(cmd_if.cmd_ready_out), 32'h1);
    do_tick(7, 6, 5, 3'b000, 1'b1);
    do_tick(6, 7, 4, 3'b000, 1'b1);
    do_tick(5, 8, 3, 3'b000, 1'b1);
    do_tick(4, 9, 2, 3'b000, 1'b1);
    do_tick(4, 9, 1, 3'b000, 1'b1);
    do_tick(4, 9, 0, 3'b100, 1'b0);

    // Out-of-range channel, then broadcast
    check("err_clear", 32'(err), 32'h0);
    send_cmd(2'b00, 3'd3, 4'd7);
    idle();
    check("err_set", 32'(err), 32'h1);
    do_tick(4, 9, 0, 3'b100, 1'b0);
    send_cmd(2'b10, 3'd2, 4'd0);
    send_cmd(2'b11, 3'd3, 4'd2);
    idle();
    check("err_sticky", 32'(err), 32'h1);
    do_tick(3, 8, 1, 3'b000, 1'b1);
    do_tick(2, 7, 2, 3'b000, 1'b1);
    for (int k = 6; k >= 2; k--) do_tick(2, 4'(k), 2, 3'b000, (k != 2));

    // Asynchronous reset in the middle of a ramp
    send_cmd(2'b00, 3'd0, 4'd9);
    do_tick(3, 2, 2, 3'b000, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("areset_vol", 32'(volume), 32'h0);
    check("areset_mute", 32'(mute), 32'h0);
    check("areset_err", 32'(err), 32'h0);
    check("areset_ready", 32'(cmd_if.cmd_ready_out), 32'h1);
    check("areset_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
